ps2_arrow_decoder: RTL

Receives scan-code frames from a PS/2 keyboard and turns arrow-key make/break sequences into a held 4-bit direction vector. This vector drives the `control[3:0]` input of the sprite position generator. The block owns the keyboard-to-game end of the movement interface: a bit is high while its key is held and low once it is released. Frame errors, line timeouts and keyboard overrun codes are all handled without corrupting held state.

---
 rtl/ps2_pkg.sv | 61 ++++++
 rtl/ps2_arrow_decoder_rx.sv | 80 ++++++++
 rtl/ps2_arrow_decoder.sv | 102 ++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 arrow-key decoder.
// The WASD codes are only acted on when PS2_WASD_EN is defined.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_NUL   = 8'h00;
    localparam logic [7:0] SC_OVR   = 8'hFF;

    localparam int UP    = 3;
    localparam int DOWN  = 2;
    localparam int LEFT  = 1;
    localparam int RIGHT = 0;

    // One-hot control mask for an extended arrow code, zero for anything else.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            SC_UP:    m[UP]    = 1'b1;
            SC_DOWN:  m[DOWN]  = 1'b1;
            SC_LEFT:  m[LEFT]  = 1'b1;
            SC_RIGHT: m[RIGHT] = 1'b1;
            default:  m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] wasd_mask(input logic [7:0] code);
        logic [3:0] m;
        m = 4'b0000;
        case (code)
            SC_W:    m[UP]    = 1'b1;
            SC_S:    m[DOWN]  = 1'b1;
            SC_A:    m[LEFT]  = 1'b1;
            SC_D:    m[RIGHT] = 1'b1;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic is_overrun(input logic [7:0] code);
        return (code == SC_NUL) || (code == SC_OVR);
    endfunction

endpackage

// File: rtl/ps2_arrow_decoder_rx.sv
// PS/2 frame receiver: pin synchroniser, falling-edge strobe, 11-bit shifter,
// start/parity/stop check and mid-frame idle timeout.
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       frame_error
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic [3:0]    bit_cnt_q;
    logic [9:0]    shift_q;
    logic [IW-1:0] idle_cnt_q;
    logic [7:0]    scancode_q;
    logic          code_valid_q;
    logic          frame_error_q;

    logic fall;
    logic data_bit;
    logic frame_ok;

    assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit = data_sync_q[1];
    // shift_q holds start..parity; the stop bit is the one arriving now.
    assign frame_ok = ~shift_q[0] & (^shift_q[9:1]) & data_bit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // Sync chain resets to the idle line level so release makes no edge.
            clk_sync_q    <= 3'b111;
            data_sync_q   <= 2'b11;
            bit_cnt_q     <= 4'd0;
            shift_q       <= 10'd0;
            idle_cnt_q    <= '0;
            scancode_q    <= 8'h00;
            code_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            clk_sync_q    <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q   <= {data_sync_q[0], ps2_data};
            code_valid_q  <= 1'b0;
            frame_error_q <= 1'b0;
            if (fall) begin
                idle_cnt_q <= '0;
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= 4'd0;
                    if (frame_ok) begin
                        scancode_q   <= shift_q[8:1];
                        code_valid_q <= 1'b1;
                    end else begin
                        frame_error_q <= 1'b1;
                    end
                end else begin
                    shift_q   <= {data_bit, shift_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (idle_cnt_q == IW'(TIMEOUT_CYCLES - 1)) begin
                    idle_cnt_q    <= '0;
                    bit_cnt_q     <= 4'd0;
                    frame_error_q <= 1'b1;
                end else begin
                    idle_cnt_q <= idle_cnt_q + 1'b1;
                end
            end
        end
    end

    assign scancode    = scancode_q;
    assign code_valid  = code_valid_q;
    assign frame_error = frame_error_q;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// Turns PS/2 arrow-key make/break sequences into a held {up,down,left,right}
// vector. Define PS2_WASD_EN to also accept W/S/A/D as a second key source.
module ps2_arrow_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] control,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       frame_error
);
    dec_state_e state_q;
    logic [3:0] arrow_held_q;
    logic [3:0] wasd_held;
    logic [7:0] rx_code;
    logic       rx_valid;
    logic       rx_error;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .scancode   (rx_code),
        .code_valid (rx_valid),
        .frame_error(rx_error)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            arrow_held_q <= 4'b0000;
        end else if (rx_error) begin
            // A broken frame may have been part of a prefix; resync but keep held keys.
            state_q <= ST_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_code == SC_EXT) begin
                        state_q <= ST_EXT;
                    end else if (rx_code == SC_BRK) begin
                        state_q <= ST_BRK;
                    end else if (is_overrun(rx_code)) begin
                        arrow_held_q <= 4'b0000;
                    end
                end
                ST_EXT: begin
                    if (rx_code == SC_BRK) begin
                        state_q <= ST_EXT_BRK;
                    end else begin
                        arrow_held_q <= arrow_held_q | arrow_mask(rx_code);
                        state_q      <= ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    arrow_held_q <= arrow_held_q & ~arrow_mask(rx_code);
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PS2_WASD_EN
    logic [3:0] wasd_held_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wasd_held_q <= 4'b0000;
        end else if (rx_valid) begin
            if (state_q == ST_IDLE) begin
                if (is_overrun(rx_code)) begin
                    wasd_held_q <= 4'b0000;
                end else begin
                    wasd_held_q <= wasd_held_q | wasd_mask(rx_code);
                end
            end else if (state_q == ST_BRK) begin
                wasd_held_q <= wasd_held_q & ~wasd_mask(rx_code);
            end
        end
    end

    assign wasd_held = wasd_held_q;
`else
    assign wasd_held = 4'b0000;
`endif

    assign control     = arrow_held_q | wasd_held;
    assign scancode    = rx_code;
    assign code_valid  = rx_valid;
    assign frame_error = rx_error;

endmodule
